// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority over fetch.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic       busy_reg, busy_next;
  logic       owner_reg, owner_next;
  logic [2:0] cnt_reg, cnt_next;

  logic any_req;
  logic arb_open;
  logic resp_cycle;
  logic grant;
  logic winner;

  assign any_req    = if_req | d_req;
  assign resp_cycle = busy_reg && (cnt_reg == 3'd1);
  assign arb_open   = !busy_reg || resp_cycle;
  // Gating with reset keeps every output at its reset value while reset is held.
  assign grant      = reset && arb_open && any_req;

`ifdef MEM_ARB_RR_EN
  logic last_reg, last_next;

  // On a tie the requester that did not win last time takes the RAM.
  assign winner = (if_req && d_req) ? ~last_reg : d_req;

  always_comb begin
    last_next = last_reg;
    if (grant) begin
      last_next = winner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= OWN_FETCH;
    end else begin
      last_reg <= last_next;
    end
  end
`else
  assign winner = d_req ? OWN_DATA : OWN_FETCH;
`endif

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (grant) begin
      mem_en = 1'b1;
      if (winner == OWN_DATA) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        if_gnt   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end
    end
  end

  assign if_rvalid = resp_cycle && (owner_reg == OWN_FETCH);
  assign d_rvalid  = resp_cycle && (owner_reg == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

  always_comb begin
    busy_next  = busy_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    if (grant) begin
      busy_next  = 1'b1;
      owner_next = winner;
      cnt_next   = 3'(MEM_LAT);
    end else if (busy_reg) begin
      cnt_next = cnt_reg - 3'd1;
      if (cnt_reg == 3'd1) begin
        busy_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg  <= 1'b0;
      owner_reg <= OWN_FETCH;
      cnt_reg   <= 3'd0;
    end else begin
      busy_reg  <= busy_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a small behavioural RAM (MEM_LAT = 2).
// Tie expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LAT    = 2;
  localparam logic [31:0] WORD0 = 32'h0000_0013;
  localparam logic [31:0] WORD1 = 32'h00A0_0093;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: byte-enabled writes, read data appears LAT cycles after mem_en.
  logic [31:0] ram [0:255];
  logic [31:0] rd_pipe [0:LAT-1];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[0] <= WORD0;
      ram[1] <= WORD1;
      for (int i = 0; i < LAT; i++) rd_pipe[i] <= 32'h0;
    end else begin
      if (mem_en && mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[9:2]] : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = 32'h0;
    d_be    = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic set_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_be    = be;
  endtask

  logic exp_d;
  logic prev_d;
  int   rv_count;

  initial begin
    // Reset state, with a request pending while reset is held.
    idle_inputs();
    reset = 1'b0;
    step();
    d_req = 1'b1;
    settle();
    $display("txn reset: request held during reset");
    check_value("rst_if_gnt", if_gnt, 0);
    check_value("rst_d_gnt", d_gnt, 0);
    check_value("rst_if_rvalid", if_rvalid, 0);
    check_value("rst_d_rvalid", d_rvalid, 0);
    check_value("rst_if_rdata", if_rdata, 0);
    check_value("rst_d_rdata", d_rdata, 0);
    check_value("rst_mem_en", mem_en, 0);
    check_value("rst_mem_we", mem_we, 0);
    check_value("rst_mem_be", mem_be, 0);
    check_value("rst_mem_addr", mem_addr, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    idle_inputs();
    step();
    reset = 1'b1;

    // Single fetch of word 0.
    if_req  = 1'b1;
    if_addr = 32'h0;
    settle();
    $display("txn fetch addr=0x00000000");
    check_value("f_if_gnt", if_gnt, 1);
    check_value("f_d_gnt", d_gnt, 0);
    check_value("f_mem_en", mem_en, 1);
    check_value("f_mem_addr", mem_addr, 32'h0);
    check_value("f_mem_we", mem_we, 0);
    check_value("f_mem_be", mem_be, 4'hF);
    step();
    idle_inputs();
    settle();
    check_value("f_rvalid_early", if_rvalid, 0);
    check_value("f_mem_en_busy", mem_en, 0);
    step();
    settle();
    check_value("f_rvalid", if_rvalid, 1);
    check_value("f_rdata", if_rdata, WORD0);
    check_value("f_d_rvalid", d_rvalid, 0);
    step();
    settle();
    check_value("f_rvalid_after", if_rvalid, 0);

    // Store 0x1234 to 0x100, then load it back in the store's ack cycle.
    set_data(1'b1, 32'h100, 32'h0000_1234, 4'hF);
    settle();
    $display("txn store addr=0x00000100 data=0x00001234 be=f");
    check_value("sw_d_gnt", d_gnt, 1);
    check_value("sw_if_gnt", if_gnt, 0);
    check_value("sw_mem_we", mem_we, 1);
    check_value("sw_mem_addr", mem_addr, 32'h100);
    check_value("sw_mem_wdata", mem_wdata, 32'h0000_1234);
    check_value("sw_mem_be", mem_be, 4'hF);
    step();
    idle_inputs();
    settle();
    check_value("sw_rvalid_early", d_rvalid, 0);
    check_value("sw_gnt_busy", d_gnt, 0);
    step();
    set_data(1'b0, 32'h100, 32'h0, 4'hF);
    settle();
    $display("txn load addr=0x00000100");
    check_value("sw_ack", d_rvalid, 1);
    check_value("lw_d_gnt", d_gnt, 1);
    check_value("lw_mem_we", mem_we, 0);
    step();
    idle_inputs();
    settle();
    check_value("lw_rvalid_early", d_rvalid, 0);
    step();
    settle();
    check_value("lw_rvalid", d_rvalid, 1);
    check_value("lw_rdata", d_rdata, 32'h0000_1234);
    step();

    // Tie after reset: data first, fetch granted in the data response cycle.
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h4;
    set_data(1'b0, 32'h100, 32'h0, 4'hF);
    settle();
    $display("txn tie fetch=0x00000004 load=0x00000100");
    check_value("tie_d_gnt", d_gnt, 1);
    check_value("tie_if_gnt", if_gnt, 0);
    check_value("tie_mem_addr", mem_addr, 32'h100);
    step();
    d_req = 1'b0;
    settle();
    check_value("tie_if_wait", if_gnt, 0);
    step();
    settle();
    check_value("tie_d_rvalid", d_rvalid, 1);
    check_value("tie_if_gnt_resp", if_gnt, 1);
    check_value("tie_mem_addr2", mem_addr, 32'h4);
    check_value("tie_if_rvalid0", if_rvalid, 0);
    step();
    if_req = 1'b0;
    settle();
    check_value("tie_if_rvalid1", if_rvalid, 0);
    step();
    settle();
    check_value("tie_if_rvalid", if_rvalid, 1);
    check_value("tie_if_rdata", if_rdata, WORD1);
    step();

    // Both requesters held continuously for six grants.
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0;
    set_data(1'b0, 32'h4, 32'h0, 4'hF);
    prev_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      $display("txn held tie grant %0d: d_gnt=%0d if_gnt=%0d", k, d_gnt, if_gnt);
      check_value($sformatf("held_d_gnt%0d", k), d_gnt, exp_d);
      check_value($sformatf("held_if_gnt%0d", k), if_gnt, !exp_d);
      if (k > 0) begin
        check_value($sformatf("held_d_rvalid%0d", k), d_rvalid, prev_d);
        check_value($sformatf("held_if_rvalid%0d", k), if_rvalid, !prev_d);
        check_value($sformatf("held_rdata%0d", k), prev_d ? d_rdata : if_rdata,
                    prev_d ? WORD1 : WORD0);
      end
      prev_d = exp_d;
      step();
      settle();
      check_value($sformatf("held_gap%0d", k), {31'b0, if_gnt | d_gnt}, 0);
      step();
    end
    idle_inputs();
    settle();
    check_value("held_last_rvalid", prev_d ? d_rvalid : if_rvalid, 1);
    step();

    // Byte store into a zeroed word, then read it back.
    do_reset();
    set_data(1'b1, 32'h200, 32'hAABB_CCDD, 4'b0010);
    settle();
    $display("txn store addr=0x00000200 data=0xaabbccdd be=2");
    check_value("sb_d_gnt", d_gnt, 1);
    check_value("sb_mem_be", mem_be, 4'b0010);
    step();
    idle_inputs();
    step();
    set_data(1'b0, 32'h200, 32'h0, 4'hF);
    settle();
    $display("txn load addr=0x00000200");
    check_value("sb_ack", d_rvalid, 1);
    check_value("sb_lw_gnt", d_gnt, 1);
    step();
    idle_inputs();
    step();
    settle();
    check_value("sb_rvalid", d_rvalid, 1);
    check_value("sb_rdata", d_rdata, 32'h0000_CC00);
    step();

    // Reset pulse while a load is outstanding.
    set_data(1'b0, 32'h0, 32'h0, 4'hF);
    settle();
    $display("txn load addr=0x00000000 (reset follows)");
    check_value("ro_d_gnt", d_gnt, 1);
    step();
    idle_inputs();
    reset = 1'b0;
    settle();
    check_value("ro_rvalid_in_rst", d_rvalid, 0);
    check_value("ro_mem_en_in_rst", mem_en, 0);
    step();
    reset = 1'b1;
    rv_count = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (d_rvalid) rv_count++;
      step();
    end
    check_value("ro_no_rvalid", rv_count, 0);
    set_data(1'b0, 32'h4, 32'h0, 4'hF);
    settle();
    $display("txn load addr=0x00000004 after reset");
    check_value("ro_new_gnt", d_gnt, 1);
    step();
    idle_inputs();
    step();
    settle();
    check_value("ro_new_rvalid", d_rvalid, 1);
    check_value("ro_new_rdata", d_rdata, WORD1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port unified instruction/data RAM between the multi-cycle CPU's instruction-fetch path and its load/store path. It accepts one request per cycle from whichever requester wins arbitration and drives the RAM. It tracks the RAM's fixed read latency and returns the response to the winning requester. It sits between the CPU core and the RAM instance, and replaces the separate instruction and data memories.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requesters and the RAM port
- MEM_LAT, 1, RAM cycles from accepted access to valid read data; legal range 1..4

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  32  fetch instruction word
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledged, this cycle
- d_rdata  out  32  load data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_be  out  4  RAM byte enables
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid MEM_LAT cycles after mem_en

## Operation
- State: busy (1 b), owner (0 = fetch, 1 = data), cnt (3 b, down-counter), last (last granted requester).
- Arbitration is open when busy=0, or when busy=1 and cnt==1 (the response cycle). The response cycle is the only overlap allowed.
- When arbitration is open and any request is present, the arbiter selects a winner in the same cycle:
  - gnt for the winner = 1; the loser's gnt stays 0.
  - mem_en = 1; mem_addr, mem_we, mem_be and mem_wdata are driven combinationally from the winner.
  - For a fetch: mem_we = 0 and mem_be = 4'hF.
- On the grant edge: busy←1, owner←winner, cnt←MEM_LAT, last←winner.
- While busy, cnt decrements each cycle. In the cycle cnt==1:
  - The owner's rvalid = 1 and its rdata = mem_rdata.
  - If no new grant occurs in that cycle, busy←0.
- A store also produces rvalid after MEM_LAT cycles, as an acknowledge. d_rdata is don't-care on a store acknowledge.
- Fixed priority (default): data beats fetch when both request.
- When mem_en = 0, the non-selected requester's rdata and all mem_* data outputs are 0.
- Addresses are forwarded unmodified; word alignment is the requester's responsibility.

## Timing
- Reset values: if_gnt = if_rvalid = d_gnt = d_rvalid = 0, all rdata = 0, mem_en = mem_we = 0, mem_be/mem_addr/mem_wdata = 0, busy = 0, cnt = 0, last = fetch.
- Grant is in the same cycle as the request when arbitration is open (zero-cycle grant). A request that arrives while not open waits until it is.
- Latency: request granted at cycle T → rvalid at cycle T+MEM_LAT.
- Throughput: one access per MEM_LAT cycles. With MEM_LAT = 1, back-to-back grants occur every cycle.
- Simultaneous response and grant: in the cycle cnt==1, the old owner's rvalid and the new winner's gnt may both be 1. These may go to the same requester or to different requesters.
- Reset asserted mid-transaction: the outstanding access is dropped and no rvalid is ever produced for it. Outputs go to reset values immediately (asynchronous).
- The requester may drop req in the cycle after gnt. Dropping req before gnt is permitted and withdraws the request.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester not equal to last wins. After reset last = fetch, so data wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. The last register is not used and may be removed.

## Test plan
- Single fetch, MEM_LAT = 1: if_req=1, if_addr=0x0 at T → if_gnt=1 at T, mem_en=1, mem_addr=0x0; at T+1 if_rvalid=1, if_rdata = RAM word 0.
- Store then load, MEM_LAT = 2: sw 0x1234 to 0x100 granted at T → d_rvalid at T+2; lw 0x100 granted at T+2 → d_rvalid at T+4 with d_rdata = 0x00001234.
- Tie, fixed priority: if_req and d_req both held high → d_gnt first. if_gnt is 0 until the data access's response cycle, then if_gnt=1.
- Tie, MEM_ARB_RR_EN, MEM_LAT = 1: both requesters held high for 6 cycles → grants alternate data, fetch, data, fetch, data, fetch.
- Reset mid-op, MEM_LAT = 3: d_req lw granted at T, reset low at T+1 for one cycle → d_rvalid never 1. The next request after reset is granted normally.
- Byte store: d_be=4'b0010, d_wdata=0xAABBCCDD to 0x200 over 0x0 → a following lw of 0x200 returns 0x0000CC00.
